fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the dual-clock FIFO among NREQ requesters in the wr_clk domain. A winner holds the port for a burst of up to MAX_BURST words, then must re-arbitrate. The arbiter never drives a write while the FIFO reports full. It flags any overflow the FIFO reports as a protocol error.

---
 rtl/fifo_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the dual-clock FIFO write port among NREQ wr_clk-domain requesters.
// Optional FIFO_ARB_STATS_EN adds per-requester accepted-word counters on stat_words_o.
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       wr_clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ*DATA_WIDTH-1:0] data_i,
    output logic [NREQ-1:0]            ack_o,
    output logic [NREQ-1:0]            grant_o,
    input  logic                       full_i,
    input  logic                       overflw_i,
    output logic                       wrEn_o,
    output logic [DATA_WIDTH-1:0]      wdata_o,
    output logic                       busy_o,
    output logic                       err_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]         stat_words_o
`endif
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state, w_stateNext;
    logic [NREQ-1:0] r_grant, w_grantNext;
    logic [IDXW-1:0] r_gIdx, w_gIdxNext;
    logic [IDXW-1:0] r_rrPtr, w_rrPtrNext;
    logic [CNTW-1:0] r_burstCnt, w_burstCntNext;
    logic            r_err;

    logic [IDXW-1:0] w_winIdx;
    logic            w_winFound;
    logic [IDXW-1:0] w_gIdxInc;
    logic            w_wrEn;

    // Search from the rotating pointer upward, wrapping modulo NREQ.
    always_comb begin
        int j;
        j          = 0;
        w_winIdx   = '0;
        w_winFound = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(r_rrPtr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_winFound && req_i[IDXW'(j)]) begin
                w_winFound = 1'b1;
                w_winIdx   = IDXW'(j);
            end
        end
    end

    assign w_gIdxInc = (r_gIdx == IDXW'(NREQ - 1)) ? '0 : r_gIdx + 1'b1;

    always_comb begin
        w_stateNext    = r_state;
        w_grantNext    = r_grant;
        w_gIdxNext     = r_gIdx;
        w_rrPtrNext    = r_rrPtr;
        w_burstCntNext = r_burstCnt;
        case (r_state)
            IDLE: begin
                if (w_winFound) begin
                    w_stateNext           = BUSY;
                    w_grantNext           = '0;
                    w_grantNext[w_winIdx] = 1'b1;
                    w_gIdxNext            = w_winIdx;
                    w_burstCntNext        = '0;
                end
            end
            BUSY: begin
                if (!req_i[r_gIdx]) begin
                    w_stateNext    = IDLE;
                    w_grantNext    = '0;
                    w_rrPtrNext    = w_gIdxInc;
                    w_burstCntNext = '0;
                end else if (!full_i) begin
                    if (r_burstCnt == CNTW'(MAX_BURST - 1)) begin
                        w_stateNext    = IDLE;
                        w_grantNext    = '0;
                        w_rrPtrNext    = w_gIdxInc;
                        w_burstCntNext = '0;
                    end else begin
                        w_burstCntNext = r_burstCnt + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_grantNext = '0;
            end
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_gIdx     <= '0;
            r_rrPtr    <= '0;
            r_burstCnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_grant    <= w_grantNext;
            r_gIdx     <= w_gIdxNext;
            r_rrPtr    <= w_rrPtrNext;
            r_burstCnt <= w_burstCntNext;
            if (overflw_i) begin
                r_err <= 1'b1;
            end
        end
    end

    // Reset gates the write strobe so a burst cut by reset produces no partial ack.
    assign w_wrEn  = (r_state == BUSY) && req_i[r_gIdx] && !full_i && !rst;
    assign wrEn_o  = w_wrEn;
    assign ack_o   = w_wrEn ? r_grant : '0;
    assign wdata_o = (r_state == BUSY) ? data_i[r_gIdx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign grant_o = r_grant;
    assign busy_o  = (r_state == BUSY);
    assign err_o   = r_err;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] r_statCnt [NREQ];

    always_ff @(posedge wr_clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (rst) begin
                r_statCnt[k] <= '0;
            end else if (ack_o[k] && (r_statCnt[k] != 16'hFFFF)) begin
                r_statCnt[k] <= r_statCnt[k] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_words_o[g*16 +: 16] = r_statCnt[g];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter: scoreboard of expected writes checked with immediate assertions.
// Build with FIFO_ARB_STATS_EN defined to also check the per-requester word counters.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic                 wr_clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*DW-1:0]   data_i;
    logic                 full_i;
    logic                 overflw_i;
    logic [NREQ-1:0]      ack_o;
    logic [NREQ-1:0]      grant_o;
    logic                 wrEn_o;
    logic [DW-1:0]        wdata_o;
    logic                 busy_o;
    logic                 err_o;
`ifdef FIFO_ARB_STATS_EN
    logic [NREQ*16-1:0]   stat_words_o;
`endif

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(
        .NREQ(NREQ),
        .DATA_WIDTH(DW),
        .MAX_BURST(MAXB)
    ) dut (
        .wr_clk(wr_clk),
        .rst(rst),
        .req_i(req_i),
        .data_i(data_i),
        .ack_o(ack_o),
        .grant_o(grant_o),
        .full_i(full_i),
        .overflw_i(overflw_i),
        .wrEn_o(wrEn_o),
        .wdata_o(wdata_o),
        .busy_o(busy_o),
        .err_o(err_o)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_words_o(stat_words_o)
`endif
    );

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic [DW-1:0]   data;
    } wr_t;

    wr_t expQ[$];
    int  total = 0;
    int  bad   = 0;
    int  wordIdx [NREQ];
    int  expIdx  [NREQ];
    int  expAcks [NREQ];
    int  used;

    function automatic logic [DW-1:0] wordOf(input int k, input int w);
        return DW'((k << 6) | (w & 63));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic driveData();
        for (int k = 0; k < NREQ; k++) begin
            data_i[k*DW +: DW] = wordOf(k, wordIdx[k]);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] req,
                                 input logic full, input logic ovf);
        rst       = r;
        req_i     = req;
        full_i    = full;
        overflw_i = ovf;
    endtask

    task automatic pushBurst(input int k, input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.ack    = '0;
            e.ack[k] = 1'b1;
            e.data   = wordOf(k, expIdx[k]);
            expQ.push_back(e);
            expIdx[k]++;
            expAcks[k]++;
        end
    endtask

    // One clock: monitor at negedge, requesters advance after the posedge on their ack.
    task automatic cycle();
        wr_t             e;
        logic [NREQ-1:0] ackSeen;
        @(negedge wr_clk);
        if (wrEn_o === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 32'(wrEn_o), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("wr_ack", 32'(ack_o), 32'(e.ack));
                checkOutput("wr_data", 32'(wdata_o), 32'(e.data));
            end
        end
        ackSeen = ack_o;
        @(posedge wr_clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (ackSeen[k] === 1'b1) begin
                wordIdx[k]++;
            end
        end
        driveData();
    endtask

    task automatic runUntilEmpty(input string tag, input int budget, output int n);
        n = 0;
        while ((expQ.size() > 0) && (n < budget)) begin
            cycle();
            n++;
        end
        checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            wordIdx[k] = 0;
            expIdx[k]  = 0;
            expAcks[k] = 0;
        end
        data_i = '0;
        driveData();
        applyStimulus(1'b1, '0, 1'b0, 1'b0);
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        checkOutput("rst_grant", 32'(grant_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_wren", 32'(wrEn_o), 32'd0);
        checkOutput("rst_ack", 32'(ack_o), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        checkOutput("rst_wdata", 32'(wdata_o), 32'd0);
        @(posedge wr_clk);
        #1;

        $display("[TB] reset mid-burst");
        applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
        pushBurst(0, 2);
        runUntilEmpty("a", 10, used);
        checkOutput("a_cycles", 32'(used), 32'd3);
        applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
        @(negedge wr_clk);
        checkOutput("a_rst_wren", 32'(wrEn_o), 32'd0);
        checkOutput("a_rst_ack", 32'(ack_o), 32'd0);
        checkOutput("a_rst_busy_before", 32'(busy_o), 32'd1);
        @(posedge wr_clk);
        #1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < NREQ; k++) expAcks[k] = 0;
        @(negedge wr_clk);
        checkOutput("a_grant_after", 32'(grant_o), 32'd0);
        checkOutput("a_busy_after", 32'(busy_o), 32'd0);
        checkOutput("a_wren_after", 32'(wrEn_o), 32'd0);
        @(posedge wr_clk);
        #1;

        $display("[TB] all requesters continuous");
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
        pushBurst(0, 4);
        pushBurst(1, 4);
        pushBurst(2, 4);
        pushBurst(3, 4);
        pushBurst(0, 4);
        runUntilEmpty("c", 40, used);
        checkOutput("c_cycles", 32'(used), 32'd25);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] single requester");
        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
        pushBurst(2, 8);
        runUntilEmpty("b", 20, used);
        checkOutput("b_cycles", 32'(used), 32'd10);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        @(negedge wr_clk);
        checkOutput("b_idle_busy", 32'(busy_o), 32'd0);
        checkOutput("b_idle_grant", 32'(grant_o), 32'd0);
        checkOutput("b_idle_wdata", 32'(wdata_o), 32'd0);
        @(posedge wr_clk);
        #1;

        $display("[TB] early drop");
        applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0);
        cycle();
        checkOutput("d_grant", 32'(grant_o), 32'h2);
        applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
        pushBurst(1, 2);
        runUntilEmpty("d1", 10, used);
        checkOutput("d1_cycles", 32'(used), 32'd2);
        applyStimulus(1'b0, 4'b1001, 1'b0, 1'b0);
        pushBurst(3, 4);
        pushBurst(0, 4);
        runUntilEmpty("d2", 20, used);
        checkOutput("d2_cycles", 32'(used), 32'd11);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
        pushBurst(2, 4);
        repeat (3) cycle();
        checkOutput("e_prefill", 32'(expQ.size()), 32'd2);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge wr_clk);
            checkOutput("e_stall_wren", 32'(wrEn_o), 32'd0);
            checkOutput("e_stall_ack", 32'(ack_o), 32'd0);
            checkOutput("e_stall_grant", 32'(grant_o), 32'h4);
            checkOutput("e_stall_busy", 32'(busy_o), 32'd1);
            @(posedge wr_clk);
            #1;
        end
        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
        runUntilEmpty("e", 10, used);
        checkOutput("e_cycles", 32'(used), 32'd2);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        @(negedge wr_clk);
        checkOutput("e_end_busy", 32'(busy_o), 32'd0);
        checkOutput("e_end_wren", 32'(wrEn_o), 32'd0);
        @(posedge wr_clk);
        #1;

        $display("[TB] overflow flag");
        checkOutput("f_err_before", 32'(err_o), 32'd0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
        @(posedge wr_clk);
        #1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("f_err_set", 32'(err_o), 32'd1);
        repeat (3) @(posedge wr_clk);
        #1;
        checkOutput("f_err_sticky", 32'(err_o), 32'd1);
`ifdef FIFO_ARB_STATS_EN
        for (int k = 0; k < NREQ; k++) begin
            checkOutput($sformatf("f_stat%0d", k), 32'(stat_words_o[k*16 +: 16]), 32'(expAcks[k]));
        end
`endif
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
        @(posedge wr_clk);
        #1;
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        checkOutput("f_err_cleared", 32'(err_o), 32'd0);
`ifdef FIFO_ARB_STATS_EN
        for (int k = 0; k < NREQ; k++) begin
            checkOutput($sformatf("f_stat%0d_cleared", k), 32'(stat_words_o[k*16 +: 16]), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
